// File: rtl/mi32_arbiter.sv
// rtl/mi32_arbiter.sv - round-robin arbiter joining several MI32 masters onto one downstream port
// Read data wait is bounded by TIMEOUT; a timed-out read returns TIMEOUT_DATA.
module mi32_arbiter #(
  parameter int          MASTERS      = 2,
  parameter int          TIMEOUT      = 1024,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEADDEAD
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [MASTERS*32-1:0] IN_DWR,
  input  logic [MASTERS*32-1:0] IN_ADDR,
  input  logic [MASTERS*4-1:0]  IN_BE,
  input  logic [MASTERS-1:0]    IN_RD,
  input  logic [MASTERS-1:0]    IN_WR,
  output logic [MASTERS-1:0]    IN_ARDY,
  output logic [MASTERS*32-1:0] IN_DRD,
  output logic [MASTERS-1:0]    IN_DRDY,
  output logic [31:0]           OUT_DWR,
  output logic [31:0]           OUT_ADDR,
  output logic [3:0]            OUT_BE,
  output logic                  OUT_RD,
  output logic                  OUT_WR,
  input  logic                  OUT_ARDY,
  input  logic [31:0]           OUT_DRD,
  input  logic                  OUT_DRDY,
  output logic                  TIMEOUT_PULSE
);

  localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST   = GW'(MASTERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA} state_t;

  logic          r_rst_meta, r_rst_sync;
  state_t        r_state, w_state_nxt;
  logic [GW-1:0] r_grant, w_grant_nxt;
  logic [GW-1:0] r_ptr, w_ptr_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [GW-1:0] w_winner;
  logic [MASTERS-1:0] w_req;
  logic          w_sel_rd, w_sel_wr;
  logic [31:0]   w_drd;

  // Assert asynchronously, release two clocks after RESET_N rises.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  always_ff @(posedge CLK or negedge r_rst_sync) begin
    if (!r_rst_sync) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_req    = IN_RD | IN_WR;
  assign w_sel_rd = IN_RD[r_grant];
  assign w_sel_wr = IN_WR[r_grant];

  // Scan from the highest offset down so the requester nearest r_ptr wins.
  always_comb begin
    int v_idx;
    w_winner = r_ptr;
    for (int i = MASTERS - 1; i >= 0; i--) begin
      v_idx = (int'(r_ptr) + i) % MASTERS;
      if (w_req[v_idx]) w_winner = GW'(v_idx);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    OUT_DWR       = '0;
    OUT_ADDR      = '0;
    OUT_BE        = '0;
    OUT_RD        = 1'b0;
    OUT_WR        = 1'b0;
    IN_ARDY       = '0;
    IN_DRDY       = '0;
    TIMEOUT_PULSE = 1'b0;
    w_drd         = OUT_DRD;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_grant_nxt = w_winner;
          w_ptr_nxt   = (w_winner == G_LAST) ? '0 : w_winner + 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        OUT_DWR  = IN_DWR[32*r_grant +: 32];
        OUT_ADDR = IN_ADDR[32*r_grant +: 32];
        OUT_BE   = IN_BE[4*r_grant +: 4];
        OUT_RD   = w_sel_rd;
        OUT_WR   = w_sel_wr;
        // A master that withdrew its request before acceptance is simply dropped.
        if (!w_sel_rd && !w_sel_wr) begin
          w_state_nxt = S_IDLE;
        end else if (OUT_ARDY) begin
          IN_ARDY[r_grant] = 1'b1;
          if (w_sel_rd) begin
            if (OUT_DRDY) begin
              IN_DRDY[r_grant] = 1'b1;
              w_state_nxt      = S_IDLE;
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_RDATA;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RDATA: begin
        if (OUT_DRDY) begin
          IN_DRDY[r_grant] = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          IN_DRDY[r_grant] = 1'b1;
          TIMEOUT_PULSE    = 1'b1;
          w_drd            = TIMEOUT_DATA;
          w_state_nxt      = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign IN_DRD = {MASTERS{w_drd}};

endmodule

// File: tb/tb_mi32_arbiter.sv
// tb/tb_mi32_arbiter.sv - self-checking bench for mi32_arbiter
module tb_mi32_arbiter;
  localparam int M  = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [M*32-1:0] in_dwr, in_addr, in_drd;
  logic [M*4-1:0]  in_be;
  logic [M-1:0]    in_rd, in_wr, in_ardy, in_drdy;
  logic [31:0]     out_dwr, out_addr, out_drd;
  logic [3:0]      out_be;
  logic            out_rd, out_wr, out_ardy, out_drdy, tpulse;

  mi32_arbiter #(.MASTERS(M), .TIMEOUT(TO), .TIMEOUT_DATA(32'hDEADDEAD)) dut (
    .CLK(clk), .RESET_N(rst_n),
    .IN_DWR(in_dwr), .IN_ADDR(in_addr), .IN_BE(in_be), .IN_RD(in_rd), .IN_WR(in_wr),
    .IN_ARDY(in_ardy), .IN_DRD(in_drd), .IN_DRDY(in_drdy),
    .OUT_DWR(out_dwr), .OUT_ADDR(out_addr), .OUT_BE(out_be), .OUT_RD(out_rd), .OUT_WR(out_wr),
    .OUT_ARDY(out_ardy), .OUT_DRD(out_drd), .OUT_DRDY(out_drdy), .TIMEOUT_PULSE(tpulse)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1, d0;
    logic        ardy, drdy;
    logic [31:0] drd;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_dwr;
    logic [1:0]  e_ardy, e_drdy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a0,
                     input logic [31:0] a1, input logic [31:0] d0, input logic ardy,
                     input logic drdy, input logic [31:0] drd, input logic e_rd, input logic e_wr,
                     input logic [31:0] e_addr, input logic [31:0] e_dwr,
                     input logic [1:0] e_ardy, input logic [1:0] e_drdy);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a0 = a0; v.a1 = a1; v.d0 = d0;
    v.ardy = ardy; v.drdy = drdy; v.drd = drd;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_dwr = e_dwr;
    v.e_ardy = e_ardy; v.e_drdy = e_drdy;
    tbl.push_back(v);
  endtask

  function automatic int rr(input logic [M-1:0] r, input int p);
    int idx;
    for (int k = 0; k < M; k++) begin
      idx = (p + k) % M;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic idle_inputs();
    in_rd = '0; in_wr = '0; in_addr = '0; in_dwr = '0; in_be = 8'hC3;
    out_ardy = 1'b0; out_drdy = 1'b0; out_drd = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // Random-phase master, slave and reference-model state
  bit          has_t[M], t_rd[M], t_wr[M], t_wait[M];
  logic [31:0] t_addr[M], t_dwr[M];
  logic [3:0]  t_be[M];
  bit          s_pend;
  int          s_cnt;
  bit          md_busy, md_wait, md_done;
  int          md_g, md_ptr, n_done, k;
  logic [M-1:0] req, e_mask;
  bit          found;

  initial begin
    // Reset state: outputs quiet even with requests and responses present
    rst_n = 1'b0;
    idle_inputs();
    in_rd = 2'b11; out_ardy = 1'b1; out_drdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_wr", out_wr, 0);
    chk("rst_in_ardy", in_ardy, 0);
    chk("rst_in_drdy", in_drdy, 0);
    chk("rst_tpulse", tpulse, 0);
    do_reset();

    //   rd     wr     a0      a1      d0            ardy drdy drd           erd ewr eaddr   edwr          eardy  edrdy
    add(2'b00, 2'b00, 32'h0,   32'h0,   32'h0,        0,   0,   32'h0,        0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b00, 2'b01, 32'h10,  32'h0,   32'h12345678, 1,   0,   32'h0,        0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b00, 2'b01, 32'h10,  32'h0,   32'h12345678, 1,   0,   32'h0,        0,  1,  32'h10,  32'h12345678, 2'b01, 2'b00);
    add(2'b00, 2'b00, 32'h10,  32'h0,   32'h12345678, 1,   0,   32'h0,        0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b11, 2'b00, 32'h100, 32'h200, 32'h0,        1,   1,   32'hA0,       0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b11, 2'b00, 32'h100, 32'h200, 32'h0,        1,   1,   32'hA1,       1,  0,  32'h200, 32'h11111111, 2'b10, 2'b10);
    add(2'b11, 2'b00, 32'h100, 32'h200, 32'h0,        1,   1,   32'hA2,       0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b11, 2'b00, 32'h100, 32'h200, 32'h0,        1,   1,   32'hA3,       1,  0,  32'h100, 32'h0,        2'b01, 2'b01);
    add(2'b11, 2'b00, 32'h100, 32'h200, 32'h0,        1,   1,   32'hA4,       0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b11, 2'b00, 32'h100, 32'h200, 32'h0,        1,   1,   32'hA5,       1,  0,  32'h200, 32'h11111111, 2'b10, 2'b10);
    add(2'b00, 2'b00, 32'h100, 32'h300, 32'h0,        0,   0,   32'h0,        0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b10, 2'b00, 32'h100, 32'h300, 32'h0,        0,   0,   32'h0,        0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b11, 2'b00, 32'h100, 32'h300, 32'h0,        1,   0,   32'h0,        1,  0,  32'h300, 32'h11111111, 2'b10, 2'b00);
    for (int j = 0; j < 4; j++)
      add(2'b01, 2'b00, 32'h100, 32'h300, 32'h0,      0,   0,   32'h0,        0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b01, 2'b00, 32'h100, 32'h300, 32'h0,        0,   1,   32'hCAFEF00D, 0,  0,  32'h0,   32'h0,        2'b00, 2'b10);
    add(2'b01, 2'b00, 32'h100, 32'h300, 32'h0,        0,   0,   32'h0,        0,  0,  32'h0,   32'h0,        2'b00, 2'b00);
    add(2'b01, 2'b00, 32'h100, 32'h300, 32'h0,        1,   1,   32'h55,       1,  0,  32'h100, 32'h0,        2'b01, 2'b01);
    add(2'b00, 2'b00, 32'h100, 32'h300, 32'h0,        0,   1,   32'h77,       0,  0,  32'h0,   32'h0,        2'b00, 2'b00);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      in_rd = tbl[i].rd; in_wr = tbl[i].wr;
      in_addr = {tbl[i].a1, tbl[i].a0};
      in_dwr  = {32'h11111111, tbl[i].d0};
      out_ardy = tbl[i].ardy; out_drdy = tbl[i].drdy; out_drd = tbl[i].drd;
      #3;
      chk($sformatf("v%0d_out_rd", i), out_rd, tbl[i].e_rd);
      chk($sformatf("v%0d_out_wr", i), out_wr, tbl[i].e_wr);
      chk($sformatf("v%0d_in_ardy", i), in_ardy, tbl[i].e_ardy);
      chk($sformatf("v%0d_in_drdy", i), in_drdy, tbl[i].e_drdy);
      chk($sformatf("v%0d_in_drd", i), in_drd, {tbl[i].drd, tbl[i].drd});
      if (tbl[i].e_rd || tbl[i].e_wr) begin
        chk($sformatf("v%0d_out_addr", i), out_addr, tbl[i].e_addr);
        chk($sformatf("v%0d_out_dwr", i), out_dwr, tbl[i].e_dwr);
      end
    end

    // Read timeout with TIMEOUT=16, then a stray late response
    @(posedge clk); #1;
    idle_inputs(); in_rd = 2'b01; in_addr = {32'h0, 32'h400};
    #3 chk("to_arb_idle", out_rd, 0);
    @(posedge clk); #1;
    out_ardy = 1'b1;
    #3 chk("to_req_ardy", in_ardy, 2'b01);
    for (int c = 1; c <= TO; c++) begin
      @(posedge clk); #1;
      in_rd = '0; out_ardy = 1'b0; out_drdy = 1'b0; out_drd = 32'h1234;
      #3;
      chk($sformatf("to_c%0d_pulse", c), tpulse, (c == TO));
      chk($sformatf("to_c%0d_drdy", c), in_drdy, (c == TO) ? 2'b01 : 2'b00);
      if (c == TO) chk("to_data", in_drd[31:0], 32'hDEADDEAD);
    end
    @(posedge clk); #1;
    out_drdy = 1'b1; out_drd = 32'hBAD0;
    #3;
    chk("to_stray_drdy", in_drdy, 0);
    chk("to_stray_pulse", tpulse, 0);

    // Reset while waiting for read data; master 0 must win first afterwards
    @(posedge clk); #1;
    idle_inputs(); in_rd = 2'b01; in_addr = {32'h0, 32'h500};
    @(posedge clk); #1;
    out_ardy = 1'b1;
    @(posedge clk); #1;
    in_rd = '0; out_ardy = 1'b0;
    #1 out_drdy = 1'b1; out_drd = 32'h99;
    #1 chk("rr_pre_rst_drdy", in_drdy, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("rr_rst_drdy", in_drdy, 0);
    chk("rr_rst_ardy", in_ardy, 0);
    chk("rr_rst_out", {out_rd, out_wr}, 0);
    chk("rr_rst_pulse", tpulse, 0);
    out_drdy = 1'b0;
    in_rd = 2'b11; in_addr = {32'h700, 32'h600}; out_ardy = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #3;
      if (out_rd) found = 1'b1;
    end
    chk("rr_first_grant_seen", found, 1);
    chk("rr_first_grant_ardy", in_ardy, 2'b01);
    chk("rr_first_grant_addr", out_addr, 32'h600);

    // Randomized traffic against a transaction-level reference model
    do_reset();
    for (int i = 0; i < M; i++) begin has_t[i] = 0; t_wait[i] = 0; end
    s_pend = 0; md_busy = 0; md_wait = 0; md_ptr = 0; md_g = 0; n_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < M; i++) begin
        if (!has_t[i] && $urandom_range(1, 0) == 1) begin
          k = $urandom_range(9, 0);
          has_t[i] = 1; t_wait[i] = 0;
          t_rd[i] = (k < 4) || (k == 9);
          t_wr[i] = (k >= 4);
          t_addr[i] = $urandom(); t_dwr[i] = $urandom(); t_be[i] = 4'($urandom());
        end
        in_rd[i] = has_t[i] && !t_wait[i] && t_rd[i];
        in_wr[i] = has_t[i] && !t_wait[i] && t_wr[i];
        in_addr[32*i +: 32] = t_addr[i];
        in_dwr[32*i +: 32]  = t_dwr[i];
        in_be[4*i +: 4]     = t_be[i];
      end
      #1;
      out_ardy = 1'b0; out_drdy = 1'b0; out_drd = $urandom();
      if (s_pend) begin
        s_cnt--;
        if (s_cnt == 0) begin out_drdy = 1'b1; s_pend = 0; end
      end else if (out_rd || out_wr) begin
        out_ardy = ($urandom_range(1, 0) == 1);
        if (out_ardy && out_rd) begin
          if ($urandom_range(2, 0) == 0) out_drdy = 1'b1;
          else begin s_pend = 1; s_cnt = $urandom_range(8, 1); end
        end
      end else begin
        out_drdy = ($urandom_range(7, 0) == 0);
      end
      #1;
      req = in_rd | in_wr;
      chk("rnd_drd_lanes", in_drd, {out_drd, out_drd});
      chk("rnd_tpulse", tpulse, 0);
      if (!md_busy) begin
        chk("rnd_idle_out", {out_rd, out_wr}, 0);
        chk("rnd_idle_ardy", in_ardy, 0);
        chk("rnd_idle_drdy", in_drdy, 0);
        if (req != 0) begin
          md_g = rr(req, md_ptr);
          md_ptr = (md_g + 1) % M;
          md_busy = 1; md_wait = 0;
        end
      end else if (!md_wait) begin
        chk("rnd_req_rd", out_rd, t_rd[md_g]);
        chk("rnd_req_wr", out_wr, t_wr[md_g]);
        chk("rnd_req_addr", out_addr, t_addr[md_g]);
        chk("rnd_req_dwr", out_dwr, t_dwr[md_g]);
        chk("rnd_req_be", out_be, t_be[md_g]);
        e_mask = out_ardy ? (M'(1) << md_g) : '0;
        chk("rnd_req_ardy", in_ardy, e_mask);
        md_done = 0; e_mask = '0;
        if (out_ardy) begin
          if (t_rd[md_g]) begin
            if (out_drdy) begin e_mask = M'(1) << md_g; md_done = 1; end
            else md_wait = 1;
          end else md_done = 1;
        end
        chk("rnd_req_drdy", in_drdy, e_mask);
        if (md_done) md_busy = 0;
      end else begin
        chk("rnd_rdata_out", {out_rd, out_wr}, 0);
        chk("rnd_rdata_ardy", in_ardy, 0);
        e_mask = out_drdy ? (M'(1) << md_g) : '0;
        chk("rnd_rdata_drdy", in_drdy, e_mask);
        if (out_drdy) begin md_busy = 0; md_wait = 0; end
      end
      for (int i = 0; i < M; i++) begin
        if (in_ardy[i]) begin
          if (t_rd[i]) t_wait[i] = 1;
          else begin has_t[i] = 0; n_done++; end
        end
        if (in_drdy[i]) begin has_t[i] = 0; t_wait[i] = 0; n_done++; end
      end
    end
    chk("rnd_progress", (n_done > 100), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mi32_arbiter.md
MI32_ARBITER -- requirements
Module: mi32_arbiter

Interface
REQ-001 SHALL have parameter MASTERS, default 2, the number of upstream MI32 masters (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 1024, the read-data wait limit in CLK cycles (>=2).
REQ-003 SHALL have parameter TIMEOUT_DATA, default 32'hDEADDEAD, the read data returned on timeout.
REQ-004 SHALL have port CLK  in  1  the single clock; all logic is in this domain.
REQ-005 SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-006 SHALL have port IN_DWR  in  MASTERS*32  write data, master i at bits [32i+31:32i].
REQ-007 SHALL have port IN_ADDR  in  MASTERS*32  address per master.
REQ-008 SHALL have port IN_BE  in  MASTERS*4  byte enables per master.
REQ-009 SHALL have ports IN_RD and IN_WR  in  MASTERS each  read/write request per master.
REQ-010 SHALL have port IN_ARDY  out  MASTERS  request accepted, per master.
REQ-011 SHALL have ports IN_DRD  out  MASTERS*32 and IN_DRDY  out  MASTERS  read data and valid per master.
REQ-012 SHALL have ports OUT_DWR/OUT_ADDR  out  32, OUT_BE  out  4, OUT_RD/OUT_WR  out  1  shared downstream request.
REQ-013 SHALL have ports OUT_ARDY  in  1, OUT_DRD  in  32, OUT_DRDY  in  1  downstream response.
REQ-014 SHALL have port TIMEOUT_PULSE  out  1  one-cycle pulse per timed-out read.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RDATA.
REQ-016 In IDLE, when any IN_RD|IN_WR is set, SHALL register a grant to one requester by round-robin starting at the master after the last granted one, then move to REQ; the grant takes effect the next cycle (1-cycle arbitration latency).
REQ-017 In REQ, SHALL drive OUT_* from the granted master's IN_* combinationally; all other masters see IN_ARDY=0.
REQ-018 In REQ, SHALL pass OUT_ARDY to the granted master's IN_ARDY only.
REQ-019 In REQ, a write with OUT_ARDY=1 SHALL return to IDLE.
REQ-020 In REQ, a read with OUT_ARDY=1 and OUT_DRDY=1 in the same cycle SHALL complete and return to IDLE.
REQ-021 In REQ, a read with OUT_ARDY=1 and OUT_DRDY=0 SHALL move to RDATA.
REQ-022 In REQ, if the granted master drops RD and WR before ARDY (protocol violation), SHALL return to IDLE and issue nothing.
REQ-023 If IN_RD and IN_WR are both set on a master, SHALL forward both to the downstream port; completion then follows the read rules.
REQ-024 In RDATA, OUT_RD and OUT_WR SHALL be 0; OUT_DRDY=1 SHALL route OUT_DRD to the granted master with IN_DRDY=1 for one cycle, then return to IDLE.
REQ-025 IN_DRDY of non-granted masters SHALL be 0; IN_DRD SHALL be OUT_DRD on all lanes.
REQ-026 SHALL run a wait counter in RDATA, cleared on entry and counting every cycle.
REQ-027 When the counter reaches TIMEOUT-1 without OUT_DRDY, SHALL return TIMEOUT_DATA with IN_DRDY=1 to the granted master, pulse TIMEOUT_PULSE and go to IDLE.
REQ-028 OUT_DRDY in IDLE or REQ without a read in progress (late response after timeout) SHALL be ignored.
REQ-029 The round-robin pointer SHALL update on grant and wrap from MASTERS-1 to 0.
REQ-030 A single requesting master SHALL be granted back-to-back, one transaction per 2 cycles at minimum.

Reset
REQ-031 RESET_N=0 SHALL asynchronously force the FSM to IDLE, clear the counter, point round-robin at master 0 (master 0 wins first), and drive OUT_RD=OUT_WR=0, IN_ARDY=0, IN_DRDY=0, TIMEOUT_PULSE=0.
REQ-032 Reset mid-transaction SHALL drop the transaction without a response; deassertion SHALL be synchronized to CLK.

Verification
REQ-033 M0 writes ADDR=0x10, DWR=0x12345678, OUT_ARDY=1 immediately -> OUT_WR at cycle+1 with matching fields, IN_ARDY[0] pulses once, FSM back in IDLE.
REQ-034 M0 and M1 both read continuously, downstream DRDY the same cycle as ARDY -> grants alternate 0,1,0,1, each master gets its own OUT_DRD.
REQ-035 M1 reads, OUT_ARDY=1, OUT_DRDY 5 cycles later with 0xCAFEF00D -> IN_DRDY[1]=1, IN_DRD=0xCAFEF00D, M0 request held off until then.
REQ-036 TIMEOUT=16, M0 reads, OUT_DRDY never asserted -> at RDATA cycle 16, IN_DRDY[0]=1 with 0xDEADDEAD and TIMEOUT_PULSE=1; a later stray OUT_DRDY is ignored.
REQ-037 RESET_N low while in RDATA -> outputs go idle immediately; after release, M0 wins first when both masters request.
